// File: rtl/seq_pkg.sv
// Shared types and default sizing for the layer sequencer and its watchdog.
// No logic; state encoding plus parameter defaults only.
package seq_pkg;

    localparam int NUM_LAYERS_DEF     = 4;
    localparam int TIMEOUT_CYCLES_DEF = 1 << 20;
    localparam int CNT_W_DEF          = 32;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ARM  = 3'd1,
        RUN  = 3'd2,
        NEXT = 3'd3,
        DONE = 3'd4,
        ERR  = 3'd5
    } seq_state_t;

endpackage

// File: rtl/watchdog_timer.sv
// Per-layer watchdog: counts enabled cycles since the last clear, flags LIMIT-1 reached.
// expired is a decode of the registered count; no handshake.
module watchdog_timer #(
    parameter int LIMIT = 1 << 20
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int W = (LIMIT > 1) ? $clog2(LIMIT) : 1;

    logic [W-1:0] r_count;

    // Counter parks at the limit so expired stays asserted until the next clear.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            r_count <= '0;
        end else if (en && !expired) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign expired = (r_count == W'(LIMIT - 1));

endmodule

// File: rtl/layer_sequencer.sv
// Runs the CNN layer modules one at a time, flipping the ping-pong bank between layers.
// Start-to-arm 1 cycle, 2-cycle layer hand-off; start is ignored while busy.
module layer_sequencer
    import seq_pkg::*;
#(
    parameter int NUM_LAYERS     = NUM_LAYERS_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
    parameter int CNT_W          = CNT_W_DEF,
    localparam int LW            = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [NUM_LAYERS-1:0] layer_reset,
    output logic [NUM_LAYERS-1:0] layer_valid,
    input  logic [NUM_LAYERS-1:0] layer_done,
    output logic [LW-1:0]         cur_layer,
    output logic                  bank_sel,
    output logic [CNT_W-1:0]      cycle_count
);

    localparam logic [LW-1:0] LAST_LAYER = LW'(NUM_LAYERS - 1);

    seq_state_t            r_state;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_err;
    logic [NUM_LAYERS-1:0] r_lrst;
    logic [NUM_LAYERS-1:0] r_valid;
    logic [LW-1:0]         r_cur;
    logic                  r_bank;
    logic [CNT_W-1:0]      r_cnt;
    logic                  w_expired;
    logic                  w_start_ok;

    watchdog_timer #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_wdog (
        .clk     (clk),
        .reset   (reset),
        .clr     (r_state == ARM),
        .en      (r_state == RUN),
        .expired (w_expired)
    );

    // The first DONE/ERR cycle still has busy high, so start waits one cycle there.
    assign w_start_ok = start && !r_busy &&
                        (r_state == IDLE || r_state == DONE || r_state == ERR);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_lrst  <= '1;
            r_valid <= '0;
            r_cur   <= '0;
            r_bank  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_valid <= '0;
            if (r_busy && (r_cnt != '1)) begin
                r_cnt <= r_cnt + 1'b1;
            end
            case (r_state)
                ARM: begin
                    r_lrst[r_cur]  <= 1'b0;
                    r_valid[r_cur] <= 1'b1;
                    r_state        <= RUN;
                end
                RUN: begin
                    // A finished layer beats a watchdog expiry in the same cycle.
                    if (layer_done[r_cur]) begin
                        r_state <= (r_cur == LAST_LAYER) ? DONE : NEXT;
                    end else if (w_expired) begin
                        r_state <= ERR;
                    end
                end
                NEXT: begin
                    r_lrst  <= '1;
                    r_cur   <= r_cur + 1'b1;
                    r_bank  <= ~r_bank;
                    r_state <= ARM;
                end
                DONE: begin
                    r_done <= 1'b1;
                    r_busy <= 1'b0;
                    r_lrst <= '1;
                end
                ERR: begin
                    r_err  <= 1'b1;
                    r_busy <= 1'b0;
                    r_lrst <= '1;
                end
                default: r_state <= IDLE;
            endcase
            if (w_start_ok) begin
                r_state <= ARM;
                r_cur   <= '0;
                r_bank  <= 1'b0;
                r_done  <= 1'b0;
                r_err   <= 1'b0;
                r_cnt   <= '0;
                r_busy  <= 1'b1;
            end
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign error       = r_err;
    assign layer_reset = r_lrst;
    assign layer_valid = r_valid;
    assign cur_layer   = r_cur;
    assign bank_sel    = r_bank;
    assign cycle_count = r_cnt;

endmodule

// File: tb/tb_layer_sequencer.sv
// Bench for layer_sequencer: two stub layers with programmable latency, timing predicted
// from the pass-level rules (valid edges, hand-off overhead, watchdog limit).
module tb_layer_sequencer;

    localparam int NL = 2;
    localparam int TO = 64;
    localparam int CW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          busy, done, error, bank_sel;
    logic [NL-1:0] layer_reset, layer_valid, layer_done;
    logic [0:0]    cur_layer;
    logic [CW-1:0] cycle_count;

    logic [NL-1:0] stub_d;
    logic [NL-1:0] spur;
    int            lat  [NL];
    int            age  [NL];
    int            vcyc [NL];
    logic          vbank[NL];
    int            vcount;
    int            cyc;
    int            n_chk  = 0;
    int            n_fail = 0;

    assign layer_done = stub_d | spur;

    layer_sequencer #(
        .NUM_LAYERS     (NL),
        .TIMEOUT_CYCLES (TO),
        .CNT_W          (CW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .busy        (busy),
        .done        (done),
        .error       (error),
        .layer_reset (layer_reset),
        .layer_valid (layer_valid),
        .layer_done  (layer_done),
        .cur_layer   (cur_layer),
        .bank_sel    (bank_sel),
        .cycle_count (cycle_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input longint obs, input longint exp);
        n_chk++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d, expected %0d (edge %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Layer stubs: done rises so the sequencer samples it lat cycles after the valid edge.
    initial begin
        stub_d = '0;
        vcount = 0;
        for (int k = 0; k < NL; k++) age[k] = -1;
        forever begin
            @(posedge clk);
            #1;
            if (layer_valid != '0) check("valid_onehot", $countones(layer_valid), 1);
            for (int k = 0; k < NL; k++) begin
                if (layer_valid[k]) begin
                    vcyc[k]  = cyc;
                    vbank[k] = bank_sel;
                    vcount++;
                    check("valid_unreset", layer_reset[k], 0);
                end
                if (layer_reset[k] !== 1'b0) begin
                    age[k]    = -1;
                    stub_d[k] = 1'b0;
                end else if (layer_valid[k]) begin
                    age[k] = 0;
                end else if (age[k] >= 0) begin
                    age[k]++;
                end
                if (age[k] >= 0 && lat[k] > 0 && age[k] >= lat[k] - 1) stub_d[k] = 1'b1;
            end
        end
    end

    task automatic check_reset_vals(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_error"}, error, 0);
        check({tag, "_lrst"}, layer_reset, 3);
        check({tag, "_valid"}, layer_valid, 0);
        check({tag, "_cur"}, cur_layer, 0);
        check({tag, "_bank"}, bank_sel, 0);
        check({tag, "_cnt"}, cycle_count, 0);
    endtask

    task automatic do_start(output int t);
        start = 1'b1;
        @(posedge clk);
        #1;
        t     = cyc;
        start = 1'b0;
        check("start_busy", busy, 1);
        check("start_done", done, 0);
        check("start_error", error, 0);
        check("start_cnt", cycle_count, 0);
    endtask

    task automatic wait_end(output int tend);
        int b = 0;
        while (!(done || error) && b < 2000) begin
            step(1);
            b++;
        end
        tend = cyc;
        check("end_reached", done || error, 1);
    endtask

    // Expected: v0=t+1, v1=v0+R0+2, done after v1+R1+1, count=R0+R1+4.
    task automatic run_pass(input int l0, input int l1, input bit disturb);
        int t, tend, c;
        lat[0] = l0;
        lat[1] = l1;
        vcount = 0;
        for (int k = 0; k < NL; k++) vcyc[k] = -1;
        do_start(t);
        if (disturb) begin
            step(3);
            start = 1'b1;
            spur  = 2'b10;
            step(2);
            start = 1'b0;
            spur  = '0;
        end
        wait_end(tend);
        check("valid0_edge", vcyc[0] - t, 1);
        check("valid1_edge", vcyc[1] - t, l0 + 3);
        check("bank_layer0", vbank[0], 0);
        check("bank_layer1", vbank[1], 1);
        check("done_edge", tend - t, l0 + l1 + 4);
        check("valid_count", vcount, NL);
        check("pass_done", done, 1);
        check("pass_error", error, 0);
        check("pass_busy", busy, 0);
        check("pass_cur", cur_layer, NL - 1);
        check("pass_bank", bank_sel, 1);
        check("pass_lrst", layer_reset, 3);
        check("pass_cnt", cycle_count, l0 + l1 + 4);
        c = l0 + l1 + 4;
        step(3);
        check("cnt_hold", cycle_count, c);
        check("done_hold", done, 1);
    endtask

    initial begin
        int t, tend;
        reset = 1'b1;
        start = 1'b0;
        spur  = '0;
        lat   = '{10, 10};
        step(3);
        reset = 1'b0;
        check_reset_vals("rst");

        // Reference pass from IDLE: 10+10+4 = 24 cycles.
        run_pass(10, 10, 1'b0);
        check("ref_cnt24", cycle_count, 24);

        // Back-to-back restarts from DONE with random layer latencies.
        for (int i = 0; i < 6; i++) begin
            run_pass($urandom_range(40, 1), $urandom_range(40, 1), 1'b0);
        end

        // Mid-pass start and a stray done on the idle layer change nothing.
        run_pass(12, 9, 1'b1);
        run_pass($urandom_range(40, 10), $urandom_range(30, 1), 1'b1);

        // Layer 1 never finishes: error after RUN entry + TO.
        lat    = '{12, 0};
        vcount = 0;
        do_start(t);
        wait_end(tend);
        check("to_edge", tend - vcyc[1], TO + 1);
        check("to_error", error, 1);
        check("to_done", done, 0);
        check("to_busy", busy, 0);
        check("to_cur", cur_layer, 1);
        check("to_lrst", layer_reset, 3);
        check("to_cnt", cycle_count, 12 + 3 + TO + 1);

        // Restart from ERR, then done landing exactly on expiry versus one cycle late.
        run_pass(8, 5, 1'b0);
        run_pass(8, TO, 1'b0);
        lat = '{5, TO + 1};
        do_start(t);
        wait_end(tend);
        check("late_error", error, 1);
        check("late_edge", tend - vcyc[1], TO + 1);

        // Reset during layer 1 RUN, then a clean pass from IDLE.
        lat    = '{20, 20};
        vcount = 0;
        do_start(t);
        for (int b = 0; b < 200 && vcount < 2; b++) step(1);
        check("mid_reach_l1", vcount, 2);
        step(3);
        check("mid_cur", cur_layer, 1);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        check_reset_vals("midrst");
        run_pass(5, 7, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/layer_sequencer.md
# layer_sequencer

Top-level controller for the CNN inference datapath. It runs the layer modules (Conv2D, pooling, dense, …) one at a time: it holds idle layers in reset, releases and arms the active layer, waits for that layer's `done`, and flips the ping-pong activation-bank select between layers. It sits between the HPS-facing start/status registers and the layer instances, and reports busy, done, error and a total cycle count for performance readout.

## Interface
Parameters:
- `NUM_LAYERS`, 4: number of sequenced layer modules.
- `TIMEOUT_CYCLES`, 2^20: per-layer watchdog limit in cycles.
- `CNT_W`, 32: width of the performance cycle counter.

Ports:
- `clk`  in  1  single clock.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  request a full inference pass; sampled only in IDLE, DONE or ERR.
- `busy`  out  1  high while a pass is in progress.
- `done`  out  1  level; high from pass completion until the next accepted `start` or `reset`.
- `error`  out  1  level; high after a watchdog timeout until the next accepted `start` or `reset`.
- `layer_reset`  out  NUM_LAYERS  per-layer synchronous reset; high for every layer that is not active.
- `layer_valid`  out  NUM_LAYERS  per-layer start strobe; one-hot, one cycle.
- `layer_done`  in  NUM_LAYERS  per-layer done level.
- `cur_layer`  out  $clog2(NUM_LAYERS)  index of the active layer.
- `bank_sel`  out  1  ping-pong activation bank: the active layer reads bank `bank_sel` and writes bank `!bank_sel`.
- `cycle_count`  out  CNT_W  cycles of the current or last pass.

## Operation
- All outputs are registered.
- Reset values: `busy`=0, `done`=0, `error`=0, `layer_reset`=all 1, `layer_valid`=0, `cur_layer`=0, `bank_sel`=0, `cycle_count`=0, state=IDLE.
- `reset` asserted mid-pass returns everything to these values at the next edge.
- States: IDLE, ARM, RUN, NEXT, DONE, ERR.
- IDLE / DONE / ERR, on `start`=1:
  - go to ARM;
  - set `cur_layer`=0 and `bank_sel`=0;
  - clear `done`, `error` and `cycle_count`;
  - set `busy`=1.
- ARM (1 cycle): `layer_reset[cur_layer]`=0, `layer_valid[cur_layer]`=1, then go to RUN.
- RUN:
  - `layer_reset[cur_layer]` stays 0 and `layer_valid`=0.
  - If `layer_done[cur_layer]`=1:
    - when `cur_layer`==NUM_LAYERS-1, go to DONE;
    - otherwise go to NEXT.
  - Else if the watchdog reaches TIMEOUT_CYCLES-1, go to ERR.
  - `layer_done` of any non-active layer is ignored.
- NEXT (1 cycle): reassert `layer_reset` on the finished layer, increment `cur_layer`, toggle `bank_sel`, then go to ARM.
- DONE: `done`=1, `busy`=0, all `layer_reset`=1. `cur_layer` and `bank_sel` hold their final values.
- ERR: `error`=1, `busy`=0, all `layer_reset`=1. `cur_layer` holds the failing layer index.
- Layer reset does not clear activation memory, so data in the banks persists across layer hand-offs.
- Watchdog:
  - cleared on every entry to RUN;
  - increments every cycle in RUN;
  - `layer_done` and timeout in the same cycle: `layer_done` wins.
- `cycle_count`:
  - increments every cycle while `busy`=1;
  - saturates at all-ones;
  - holds after DONE or ERR.
- `start` while `busy`=1 is ignored.
- `start` in DONE restarts immediately: `done` falls the same edge `busy` rises.

## Timing
- `start` sampled at edge t:
  - ARM outputs are visible after edge t+1 (`layer_reset[0]` falls and `layer_valid[0]` pulses);
  - RUN is entered after edge t+2.
- `layer_done[k]` sampled at edge t (not last layer):
  - NEXT after edge t+1;
  - ARM for k+1 after edge t+2 (`layer_valid[k+1]` high);
  - layer-to-layer overhead is 2 cycles.
- Last `layer_done` sampled at edge t: `done`=1 and `busy`=0 after edge t+1.
- For an N-layer pass with layer run times R_k cycles (from `layer_valid` to `done` sampled), `cycle_count` = sum(R_k) + 2N.

## Structure
- Package `seq_pkg`:
  - `seq_state_t` enum (IDLE, ARM, RUN, NEXT, DONE, ERR);
  - default `NUM_LAYERS`, `TIMEOUT_CYCLES`, `CNT_W` constants.
- Sub-module `watchdog_timer`: clear and enable inputs, `expired` output, parameterised by limit.
- The FSM, bank select and cycle counter stay in `layer_sequencer`.

## Test plan
- NUM_LAYERS=2, layer stubs assert `done` 10 cycles after `valid`; pulse `start` → `valid[0]` at t+1, `valid[1]` 2 cycles after `done[0]` is sampled, `bank_sel` 0→1, final `done`=1, `cycle_count`=24.
- Stub layer 1 never completes, TIMEOUT_CYCLES=64 → `error`=1 at RUN entry+64, `cur_layer`=1, `layer_reset`=2'b11, `busy`=0.
- `start` pulsed mid-pass and a spurious `layer_done[1]` while layer 0 is active → both ignored, sequence unchanged.
- `reset` asserted during RUN of layer 1 → next edge all outputs at reset values; a following `start` runs cleanly from layer 0 with `bank_sel`=0.
- `start` asserted in DONE → `done` falls and `busy` rises on the same edge, `cycle_count` clears to 0, a new pass completes.
- `layer_done` and watchdog expiry in the same cycle → sequencer takes the done path, `error` stays 0.
